seq_deser_8b_rx: RTL and testbench
==================================

Name: seq_deser_8b_rx

Overview:
- Serial-to-parallel receiver for an MSB-first bitstream, one bit per enabled cycle.
- Pairs with the team's 8-bit universal shift register: that block's sout drives this block's sin, with both blocks sharing the same en.
- Every 8 enabled bits form one byte.
- Completed bytes go into a small output queue and leave through a val/rdy handshake.
- Bytes that arrive while the queue cannot accept them are dropped and flagged.

Parameters:
p_depth  2  number of output queue entries (legal values 1..4)

Ports:
clk       input   1  clock; all state updates on the rising edge
reset     input   1  reset, synchronous, active-high
en        input   1  sample sin on this edge
sin       input   1  serial data bit, MSB of each byte first
partial   output  8  current shift register contents
count     output  3  bits received so far in the current byte (0..7)
out_val   output  1  queue non-empty
out_rdy   input   1  consumer accepts the head byte this cycle
out_msg   output  8  head byte of the queue; 8'h00 when the queue is empty
overflow  output  1  sticky flag: at least one byte was dropped

Behaviour:
- Reset (synchronous, wins over all other inputs):
  - partial=0, count=0, queue emptied, out_val=0, out_msg=0, overflow=0.
  - Reset asserted mid-byte discards the partial byte.
- Shift:
  - en=1: partial <= {partial[6:0], sin}; count <= count+1, wrapping from 7 to 0.
  - en=0: partial and count hold; sin is ignored.
- Byte completion: occurs on an edge where en=1 and count==7.
  - Byte {partial[6:0], sin} is offered to the queue on that same edge.
  - count wraps to 0.
  - partial takes the shifted value, the same as on any other edge.
- Dequeue: occurs on an edge where out_val && out_rdy; the head entry is removed.
  - out_rdy with out_val=0 has no effect.
- Enqueue rules at a completion edge:
  - Queue not full: the byte is written at the tail.
  - Queue full and a dequeue occurs on the same edge: the enqueue succeeds and occupancy stays at p_depth.
  - Queue full and no dequeue: the byte is dropped and overflow is set to 1.
  - overflow is cleared only by reset.
- Empty queue with enqueue and no dequeue: out_val=1 and out_msg=byte in the next cycle.
  - Latency from the 8th enabled edge to visibility is 1 cycle.
  - There is no bypass in the same cycle.
- Ordering: strict FIFO. Bytes are presented in completion order.
- out_msg:
  - Reflects the head entry combinationally from registered state.
  - Must be 8'h00 whenever out_val=0.
  - Must remain stable while out_val=1 and out_rdy=0.
- Occupancy:
  - Tracked with a head pointer, a tail pointer and a count.
  - Pointers wrap modulo p_depth.
  - Occupancy never exceeds p_depth and never underflows.
- Outputs registered or derived from registers only:
  - No combinational path from sin or en to any output.
  - out_val and out_msg do not depend on out_rdy.

Test Plan:
1. Single byte: after reset, out_rdy=1, en=1 for 8 cycles with sin=1,1,0,1,0,1,1,0.
   - Count steps 1..7 then 0.
   - After the 8th edge: out_val=1, out_msg=8'hD6, partial=8'hD6, overflow=0.
   - Next edge: out_val=0, out_msg=8'h00.
2. Enable gaps: the same bits as scenario 1, but with en=0 cycles (toggling sin) inserted after bits 3 and 6.
   - Count holds during the gaps.
   - Result is still 8'hD6, visible the cycle after the 8th enabled edge.
3. Backpressure with p_depth=2 and out_rdy=0: send 8'h65, then 8'hC9, then 8'hFF.
   - After byte 2: out_val=1, out_msg=8'h65.
   - After byte 3: overflow=1.
   - Raise out_rdy: the consumer sees 8'h65 then 8'hC9, then out_val=0. 8'hFF is never seen.
4. Simultaneous dequeue and enqueue with the queue full (holding 8'h11, 8'h22):
   - Assert out_rdy on the completion edge of 8'h33.
   - Queue then holds 8'h22, 8'h33; overflow stays 0.
5. Reset mid-operation: after 5 enabled bits with one byte queued, assert reset for 1 cycle.
   - count=0, partial=0, out_val=0, overflow=0.
   - The next 8 enabled bits 0,1,0,0,0,0,0,0 yield out_msg=8'h40.
6. Loopback: load the universal shift register with 8'hD6, then en=1 for 8 cycles with its sout tied to sin.
   - Receiver outputs 8'hD6 and count returns to 0.

Source files
------------

// File: rtl/seq_deser_8b_rx_if.sv
// Bundle for the serial receiver: bitstream in, byte queue out, plus status.
// The bit source and consumer use master; the receiver uses slave.
interface seq_deser_8b_rx_if;
  logic       en;
  logic       sin;
  logic [7:0] partial;
  logic [2:0] count;
  logic       out_val;
  logic       out_rdy;
  logic [7:0] out_msg;
  logic       overflow;

  modport master (
    output en, sin, out_rdy,
    input  partial, count, out_val, out_msg, overflow
  );

  modport slave (
    input  en, sin, out_rdy,
    output partial, count, out_val, out_msg, overflow
  );
endinterface

// File: rtl/seq_deser_8b_rx.sv
// MSB-first serial-to-parallel receiver. Each group of 8 enabled bits forms a byte
// that goes into a small FIFO and leaves over a val/rdy handshake; overflow is sticky.
module seq_deser_8b_rx #(
  parameter int p_depth = 2
) (
  input  logic              clk,
  input  logic              reset,
  seq_deser_8b_rx_if.slave  bus
);
  localparam int PW = (p_depth > 1) ? $clog2(p_depth) : 1;
  localparam int OW = $clog2(p_depth + 1);

  logic [7:0]    partial_p0;
  logic [2:0]    cnt_p0;
  logic [7:0]    mem_p1 [p_depth];
  logic [PW-1:0] head_p1;
  logic [PW-1:0] tail_p1;
  logic [OW-1:0] occ_p1;
  logic          ovf_p1;

  logic [7:0] byte_in;
  logic       complete;
  logic       val;
  logic       full;
  logic       deq;
  logic       enq;
  logic       drop;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    ptr_inc = (p == PW'(p_depth - 1)) ? '0 : p + 1'b1;
  endfunction

  always_comb begin
    byte_in  = {partial_p0[6:0], bus.sin};
    complete = bus.en && (cnt_p0 == 3'd7);
    val      = (occ_p1 != '0);
    full     = (occ_p1 == OW'(p_depth));
    deq      = val && bus.out_rdy;
    // A full queue still accepts a byte when its head leaves on the same edge.
    enq      = complete && (!full || deq);
    drop     = complete && full && !deq;
  end

  // Stage p0: bit shifter and bit counter
  always_ff @(posedge clk) begin
    if (reset) begin
      partial_p0 <= '0;
      cnt_p0     <= '0;
    end else if (bus.en) begin
      partial_p0 <= byte_in;
      cnt_p0     <= cnt_p0 + 3'd1;
    end
  end

  // Stage p1: byte queue control
  always_ff @(posedge clk) begin
    if (reset) begin
      head_p1 <= '0;
      tail_p1 <= '0;
      occ_p1  <= '0;
      ovf_p1  <= 1'b0;
    end else begin
      if (enq) tail_p1 <= ptr_inc(tail_p1);
      if (deq) head_p1 <= ptr_inc(head_p1);
      case ({enq, deq})
        2'b10:   occ_p1 <= occ_p1 + 1'b1;
        2'b01:   occ_p1 <= occ_p1 - 1'b1;
        default: occ_p1 <= occ_p1;
      endcase
      if (drop) ovf_p1 <= 1'b1;
    end
  end

  // Queue storage needs no reset; occupancy alone decides what is visible.
  always_ff @(posedge clk) begin
    if (enq) mem_p1[tail_p1] <= byte_in;
  end

  assign bus.partial  = partial_p0;
  assign bus.count    = cnt_p0;
  assign bus.out_val  = val;
  assign bus.out_msg  = val ? mem_p1[head_p1] : 8'h00;
  assign bus.overflow = ovf_p1;
endmodule

// File: tb/tb_seq_deser_8b_rx.sv
// Directed bench for seq_deser_8b_rx: table-driven single-byte and enable-gap runs,
// then hand sequences for backpressure, full-queue bypass, reset and loopback.
module tb_seq_deser_8b_rx;
  logic clk;
  logic reset;
  logic sin_drv;
  logic loop;
  logic [7:0] usr;
  logic [7:0] usr_d;
  logic usr_ld;

  int errors = 0;
  int checks = 0;

  seq_deser_8b_rx_if bus ();

  seq_deser_8b_rx #(.p_depth(2)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural stand-in for the universal shift register: sout is its MSB.
  always @(posedge clk) begin
    if (usr_ld)      usr <= usr_d;
    else if (bus.en) usr <= {usr[6:0], 1'b0};
  end

  assign bus.sin = loop ? usr[7] : sin_drv;

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic       rst;
    logic       en;
    logic       sin;
    logic       rdy;
    logic [2:0] cnt;
    logic [7:0] part;
    logic       val;
    logic [7:0] msg;
    logic       ovf;
  } vec_t;

  vec_t vq[$];

  function automatic vec_t mk(logic r, logic e, logic s, logic y,
                              logic [2:0] c, logic [7:0] p, logic v,
                              logic [7:0] m, logic o);
    vec_t t;
    t.rst = r; t.en = e; t.sin = s; t.rdy = y;
    t.cnt = c; t.part = p; t.val = v; t.msg = m; t.ovf = o;
    return t;
  endfunction

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1; bus.en = 1'b0; bus.out_rdy = 1'b0;
    tick();
    reset = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input logic rdy_body, input logic rdy_last);
    for (int i = 0; i < 8; i++) begin
      bus.en      = 1'b1;
      sin_drv     = b[7-i];
      bus.out_rdy = (i == 7) ? rdy_last : rdy_body;
      tick();
    end
    bus.en = 1'b0;
    bus.out_rdy = 1'b0;
  endtask

  initial begin
    reset = 1'b0; bus.en = 1'b0; bus.out_rdy = 1'b0;
    sin_drv = 1'b0; loop = 1'b0; usr_ld = 1'b0; usr_d = 8'h00;

    // rst en sin rdy | cnt part val msg ovf
    vq.push_back(mk(1,0,0,0, 0, 8'h00, 0, 8'h00, 0));
    vq.push_back(mk(0,1,1,1, 1, 8'h01, 0, 8'h00, 0));
    vq.push_back(mk(0,1,1,1, 2, 8'h03, 0, 8'h00, 0));
    vq.push_back(mk(0,1,0,1, 3, 8'h06, 0, 8'h00, 0));
    vq.push_back(mk(0,1,1,1, 4, 8'h0D, 0, 8'h00, 0));
    vq.push_back(mk(0,1,0,1, 5, 8'h1A, 0, 8'h00, 0));
    vq.push_back(mk(0,1,1,1, 6, 8'h35, 0, 8'h00, 0));
    vq.push_back(mk(0,1,1,1, 7, 8'h6B, 0, 8'h00, 0));
    vq.push_back(mk(0,1,0,1, 0, 8'hD6, 1, 8'hD6, 0));
    vq.push_back(mk(0,0,1,1, 0, 8'hD6, 0, 8'h00, 0));
    vq.push_back(mk(0,1,1,1, 1, 8'hAD, 0, 8'h00, 0));
    vq.push_back(mk(0,1,1,1, 2, 8'h5B, 0, 8'h00, 0));
    vq.push_back(mk(0,1,0,1, 3, 8'hB6, 0, 8'h00, 0));
    vq.push_back(mk(0,0,1,1, 3, 8'hB6, 0, 8'h00, 0));
    vq.push_back(mk(0,0,0,1, 3, 8'hB6, 0, 8'h00, 0));
    vq.push_back(mk(0,1,1,1, 4, 8'h6D, 0, 8'h00, 0));
    vq.push_back(mk(0,1,0,1, 5, 8'hDA, 0, 8'h00, 0));
    vq.push_back(mk(0,1,1,1, 6, 8'hB5, 0, 8'h00, 0));
    vq.push_back(mk(0,0,0,1, 6, 8'hB5, 0, 8'h00, 0));
    vq.push_back(mk(0,0,1,1, 6, 8'hB5, 0, 8'h00, 0));
    vq.push_back(mk(0,1,1,1, 7, 8'h6B, 0, 8'h00, 0));
    vq.push_back(mk(0,1,0,1, 0, 8'hD6, 1, 8'hD6, 0));
    vq.push_back(mk(0,0,0,1, 0, 8'hD6, 0, 8'h00, 0));

    foreach (vq[i]) begin
      reset = vq[i].rst; bus.en = vq[i].en; sin_drv = vq[i].sin; bus.out_rdy = vq[i].rdy;
      tick();
      check($sformatf("v%0d_count", i),    bus.count,    vq[i].cnt);
      check($sformatf("v%0d_partial", i),  bus.partial,  vq[i].part);
      check($sformatf("v%0d_out_val", i),  bus.out_val,  vq[i].val);
      check($sformatf("v%0d_out_msg", i),  bus.out_msg,  vq[i].msg);
      check($sformatf("v%0d_overflow", i), bus.overflow, vq[i].ovf);
    end
    reset = 1'b0; bus.en = 1'b0; bus.out_rdy = 1'b0;

    // Backpressure: third byte dropped, first two drained in order.
    do_reset();
    send_byte(8'h65, 1'b0, 1'b0);
    check("bp_val1", bus.out_val, 1);
    check("bp_msg1", bus.out_msg, 8'h65);
    for (int i = 0; i < 8; i++) begin
      bus.en = 1'b1; sin_drv = 8'hC9 >> (7 - i);
      tick();
      check("bp_msg_hold", bus.out_msg, 8'h65);
    end
    bus.en = 1'b0;
    check("bp_ovf_after2", bus.overflow, 0);
    send_byte(8'hFF, 1'b0, 1'b0);
    check("bp_ovf_after3", bus.overflow, 1);
    check("bp_head_after3", bus.out_msg, 8'h65);
    bus.out_rdy = 1'b1;
    tick();
    check("bp_drain_val1", bus.out_val, 1);
    check("bp_drain_msg1", bus.out_msg, 8'hC9);
    tick();
    check("bp_drain_val2", bus.out_val, 0);
    check("bp_drain_msg2", bus.out_msg, 8'h00);
    check("bp_ovf_sticky", bus.overflow, 1);
    bus.out_rdy = 1'b0;

    // Full queue: dequeue and enqueue on the same edge.
    do_reset();
    send_byte(8'h11, 1'b0, 1'b0);
    send_byte(8'h22, 1'b0, 1'b0);
    send_byte(8'h33, 1'b0, 1'b1);
    check("sim_ovf", bus.overflow, 0);
    check("sim_val", bus.out_val, 1);
    check("sim_head", bus.out_msg, 8'h22);
    bus.out_rdy = 1'b1;
    tick();
    check("sim_next", bus.out_msg, 8'h33);
    tick();
    check("sim_empty", bus.out_val, 0);
    bus.out_rdy = 1'b0;

    // Reset in the middle of a byte with one byte queued.
    do_reset();
    send_byte(8'hA5, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      bus.en = 1'b1; sin_drv = i[0];
      tick();
    end
    bus.en = 1'b0;
    check("rst_pre_count", bus.count, 5);
    check("rst_pre_val", bus.out_val, 1);
    reset = 1'b1; bus.en = 1'b1; sin_drv = 1'b1; bus.out_rdy = 1'b0;
    tick();
    reset = 1'b0; bus.en = 1'b0;
    check("rst_count", bus.count, 0);
    check("rst_partial", bus.partial, 8'h00);
    check("rst_val", bus.out_val, 0);
    check("rst_msg", bus.out_msg, 8'h00);
    check("rst_ovf", bus.overflow, 0);
    send_byte(8'h40, 1'b0, 1'b0);
    check("rst_after_msg", bus.out_msg, 8'h40);
    check("rst_after_val", bus.out_val, 1);

    // Loopback from the shift register model.
    do_reset();
    usr_ld = 1'b1; usr_d = 8'hD6;
    tick();
    usr_ld = 1'b0; loop = 1'b1;
    for (int i = 0; i < 8; i++) begin
      bus.en = 1'b1;
      tick();
    end
    bus.en = 1'b0; loop = 1'b0;
    check("loop_msg", bus.out_msg, 8'hD6);
    check("loop_val", bus.out_val, 1);
    check("loop_count", bus.count, 0);
    check("loop_partial", bus.partial, 8'hD6);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
